life_grid_engine: RTL and testbench
===================================

// Module: life_grid_engine
// PURPOSE
//  Parametrised Game of Life engine: ROWS x COLS cell grid, serial row-major load, one-cycle
//  fully parallel generation update, serial readout. Runs N generations or free-runs. Runtime
//  toroidal/dead-edge boundary; stable and extinct detection with optional auto-halt.
//  Sits behind the tt_um top-level FSM glue; replaces the fixed 6x6 shift-register grid.
// PARAMETERS
//  ROWS   6   grid rows (>=3)
//  COLS   6   grid columns (>=3)
//  GEN_W  8   width of gens_req / gen_count
// PORTS
//  clock           in   1      rising-edge clock
//  rst_n           in   1      async active-low reset
//  in_valid        in   1      load bit valid
//  in_bit          in   1      cell value, row-major, index r*COLS+c, cell 0 first
//  in_ready        out  1      high only in LOAD
//  start           in   1      one-cycle pulse, begin run (READY only)
//  gens_req        in   GEN_W  generations to run; 0 = free-run; sampled on start
//  wrap_en         in   1      1 = toroidal, 0 = outside cells dead; sampled on start
//  stop_on_stable  in   1      halt when stable or extinct; sampled on start
//  abort           in   1      end run, go READY
//  clear           in   1      READY only: zero grid, go LOAD
//  out_valid       out  1      readout bit valid
//  out_bit         out  1      readout cell value, row-major
//  out_last        out  1      high with cell ROWS*COLS-1
//  out_ready       in   1      readout accept
//  busy            out  1      high in COMPUTE or DRAIN
//  gen_count       out  GEN_W  generations computed since start; saturates at all-ones
//  stable          out  1      last generation equal to its predecessor
//  extinct         out  1      last generation all zero
// BEHAVIOUR
//  Reset (async, rst_n low): state=LOAD, grid=0, load/drain index=0, gen_count=0, stable=0,
//   extinct=0, out_valid=0, out_bit=0, out_last=0, busy=0; in_ready=1 (follows LOAD).
//  States: LOAD -> READY -> COMPUTE -> DRAIN -> {COMPUTE | READY}.
//  LOAD: each in_valid&in_ready writes in_bit to cell[idx], idx++; on cell ROWS*COLS-1 -> READY.
//  READY: start -> COMPUTE (latch gens_req, wrap_en, stop_on_stable; gen_count<=0; stable,
//   extinct <= 0). clear -> LOAD, grid zeroed. clear wins over start in the same cycle.
//  COMPUTE (exactly 1 cycle): all cells update in parallel; 8-neighbour sum in 4 bits;
//   alive' = (sum==3)|(alive&(sum==2)). wrap_en=1: row/col neighbour indices mod ROWS/COLS;
//   wrap_en=0: off-grid neighbours read as 0. gen_count++ (saturating). stable<=(next==cur);
//   extinct<=(next==0). Next state DRAIN with drain idx=0.
//  DRAIN: out_valid=1, out_bit=cell[idx]; idx advances only on out_valid&out_ready;
//   out_bit/out_last held stable under backpressure. After handshake on last cell:
//   -> READY if (gens_req!=0 & gen_count==gens_req) or (stop_on_stable & (stable|extinct));
//   else -> COMPUTE. Latency start->first out_valid = 2 cycles.
//  abort in COMPUTE/DRAIN: -> READY next cycle, out_valid drops, grid keeps last computed
//   generation. abort ignored in LOAD/READY.
//  Ignored: start outside READY; in_valid outside LOAD (in_ready=0); clear outside READY.
//  Grid never changes in READY/DRAIN; readout always matches gen_count generation.
// TESTING  (ROWS=COLS=6, GEN_W=8)
//  Blinker: load cells 13,14,15; start gens_req=2 wrap_en=0 -> drain1 ones at 8,14,20 only;
//   drain2 ones at 13,14,15; gen_count=2; READY; stable=0.
//  Wrap: load 5,0,1; wrap_en=1 gens_req=1 -> ones at 30,0,6; reload, wrap_en=0 -> all zero,
//   extinct=1.
//  Still life: load 0,1,6,7; gens_req=0 stop_on_stable=1 -> one drain, stable=1, gen_count=1,
//   READY.
//  Backpressure: blinker, out_ready toggled pseudo-randomly -> 36 accepted bits identical to
//   no-stall run; out_last only with 36th; out_bit constant while stalled.
//  Abort/reset: free-run, assert abort mid-DRAIN -> READY next cycle, out_valid=0; then rst_n
//   low mid-DRAIN -> all outputs at reset values immediately, in_ready=1.
//  Illegal commands: start in LOAD, in_valid in READY, clear in DRAIN -> no state/grid change.

Source files
------------

// File: rtl/life_grid_engine.sv
// Game of Life engine: ROWS x COLS grid, serial row-major load, one-cycle parallel
// generation update, serial readout with backpressure, stable/extinct detection.
module life_grid_engine #(
    parameter int ROWS  = 6,
    parameter int COLS  = 6,
    parameter int GEN_W = 8
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             start,
    input  logic [GEN_W-1:0] gens_req,
    input  logic             wrap_en,
    input  logic             stop_on_stable,
    input  logic             abort,
    input  logic             clear,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic             extinct
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_READY,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t             state;
    logic [N-1:0]       grid;
    logic [N-1:0]       next_grid;
    logic [IDX_W-1:0]   idx;
    logic [GEN_W-1:0]   gens_q;
    logic               wrap_q;
    logic               stop_q;
    logic               run_done;

    // Neighbour lookup: toroidal when wrapping, otherwise off-grid cells read as dead.
    function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c,
                                     input logic wrap);
        int rr;
        int cc;
        rr = wrap ? (r + ROWS) % ROWS : r;
        cc = wrap ? (c + COLS) % COLS : c;
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
            return 1'b0;
        end
        return g[IDX_W'(rr * COLS + cc)];
    endfunction

    always_comb begin : next_gen
        logic [3:0] sum;
        // NOTE: defaults before the loops keep every path assigned, so no latch is inferred.
        next_grid = '0;
        sum       = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sum = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            sum = sum + 4'(cell_at(grid, r + dr, c + dc, wrap_q));
                        end
                    end
                end
                next_grid[IDX_W'(r * COLS + c)] = (sum == 4'd3) ||
                    (grid[IDX_W'(r * COLS + c)] && (sum == 4'd2));
            end
        end
    end

    assign run_done = ((gens_q != '0) && (gen_count == gens_q)) ||
                      (stop_q && (stable || extinct));

    assign in_ready = (state == S_LOAD);
    assign busy     = (state == S_COMPUTE) || (state == S_DRAIN);

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            // NOTE: the grid is a flop array rather than RAM, so an async reset is legal here.
            grid      <= '0;
            idx       <= '0;
            gens_q    <= '0;
            wrap_q    <= 1'b0;
            stop_q    <= 1'b0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        grid[idx] <= in_bit;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_READY;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_READY: begin
                    // clear has priority over start
                    if (clear) begin
                        grid  <= '0;
                        idx   <= '0;
                        state <= S_LOAD;
                    end else if (start) begin
                        gens_q    <= gens_req;
                        wrap_q    <= wrap_en;
                        stop_q    <= stop_on_stable;
                        gen_count <= '0;
                        stable    <= 1'b0;
                        extinct   <= 1'b0;
                        state     <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (abort) begin
                        state <= S_READY;
                    end else begin
                        grid <= next_grid;
                        if (gen_count != '1) begin
                            gen_count <= gen_count + 1'b1;
                        end
                        stable    <= (next_grid == grid);
                        extinct   <= (next_grid == '0);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_bit   <= next_grid[0];
                        out_last  <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_bit   <= 1'b0;
                        out_last  <= 1'b0;
                        idx       <= '0;
                        state     <= S_READY;
                    end else if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_bit   <= 1'b0;
                            out_last  <= 1'b0;
                            idx       <= '0;
                            state     <= run_done ? S_READY : S_COMPUTE;
                        end else begin
                            idx      <= idx + 1'b1;
                            out_bit  <= grid[idx + 1'b1];
                            out_last <= ((idx + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine (6x6): blinker, wrap, still life, backpressure,
// abort/reset and ignored-command scenarios with hand-computed expected grids.
module tb_life_grid_engine;

    logic       clock;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       start;
    logic [7:0] gens_req;
    logic       wrap_en;
    logic       stop_on_stable;
    logic       abort;
    logic       clear;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic [7:0] gen_count;
    logic       stable;
    logic       extinct;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [35:0] BLINK_H = (36'd1 << 13) | (36'd1 << 14) | (36'd1 << 15);
    localparam logic [35:0] BLINK_V = (36'd1 << 8)  | (36'd1 << 14) | (36'd1 << 20);
    localparam logic [35:0] WRAP_H  = (36'd1 << 5)  | (36'd1 << 0)  | (36'd1 << 1);
    localparam logic [35:0] WRAP_V  = (36'd1 << 30) | (36'd1 << 0)  | (36'd1 << 6);
    localparam logic [35:0] BLOCK   = (36'd1 << 0)  | (36'd1 << 1)  | (36'd1 << 6) | (36'd1 << 7);

    life_grid_engine #(.ROWS(6), .COLS(6), .GEN_W(8)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_bit         (in_bit),
        .in_ready       (in_ready),
        .start          (start),
        .gens_req       (gens_req),
        .wrap_en        (wrap_en),
        .stop_on_stable (stop_on_stable),
        .abort          (abort),
        .clear          (clear),
        .out_valid      (out_valid),
        .out_bit        (out_bit),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .busy           (busy),
        .gen_count      (gen_count),
        .stable         (stable),
        .extinct        (extinct)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_grid(input logic [35:0] pat);
        for (int i = 0; i < 36; i++) begin
            in_valid = 1'b1;
            in_bit   = pat[i];
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] gens, input logic wrap, input logic sos);
        gens_req       = gens;
        wrap_en        = wrap;
        stop_on_stable = sos;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    // Collects one 36-bit readout; stall=1 drives out_ready pseudo-randomly.
    task automatic drain(input bit stall, output logic [35:0] bits, output int last_errs,
                         output int hold_errs, output bit timeout);
        int   n;
        int   cyc;
        bit   held;
        logic held_bit;
        logic held_last;
        n = 0; cyc = 0; held = 1'b0; held_bit = 1'b0; held_last = 1'b0;
        bits = '0; last_errs = 0; hold_errs = 0; timeout = 1'b0;
        while (n < 36) begin
            if (cyc > 500) begin
                timeout = 1'b1;
                break;
            end
            out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (held && out_valid && (out_bit !== held_bit || out_last !== held_last))
                hold_errs++;
            if (out_valid && out_ready) begin
                bits[n] = out_bit;
                if (out_last !== (n == 35)) last_errs++;
                n++;
                held = 1'b0;
            end else if (out_valid) begin
                held      = 1'b1;
                held_bit  = out_bit;
                held_last = out_last;
            end
            tick();
            cyc++;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        total_cnt++;
        if ({out_valid, out_bit, out_last, busy, in_ready, stable, extinct, gen_count} !==
            {7'b0000100, 8'h00})
            $display("FAIL reset_outputs: got v%b b%b l%b busy%b rdy%b st%b ex%b gc%0d expected rdy=1 rest 0",
                     out_valid, out_bit, out_last, busy, in_ready, stable, extinct, gen_count);
        else pass_cnt++;
    endtask

    task automatic test_blinker();
        logic [35:0] bits;
        int le, he;
        bit to;
        load_grid(BLINK_H);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL blinker_ready_after_load: in_ready=%b busy=%b expected 0 0", in_ready, busy);
        else pass_cnt++;
        start_run(8'd2, 1'b0, 1'b0);
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL blinker_compute_cycle: out_valid=%b busy=%b expected 0 1", out_valid, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_bit !== 1'b0 || out_last !== 1'b0)
            $display("FAIL blinker_latency: v=%b b=%b l=%b expected 1 0 0", out_valid, out_bit, out_last);
        else pass_cnt++;
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== BLINK_V || le != 0 || to)
            $display("FAIL blinker_gen1: got %h last_errs=%0d timeout=%b expected %h", bits, le, to, BLINK_V);
        else pass_cnt++;
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== BLINK_H || le != 0 || to)
            $display("FAIL blinker_gen2: got %h last_errs=%0d timeout=%b expected %h", bits, le, to, BLINK_H);
        else pass_cnt++;
        total_cnt++;
        if (gen_count !== 8'd2 || busy !== 1'b0 || stable !== 1'b0 || extinct !== 1'b0)
            $display("FAIL blinker_status: gc=%0d busy=%b stable=%b extinct=%b expected 2 0 0 0",
                     gen_count, busy, stable, extinct);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [35:0] bits;
        int le, he;
        bit to;
        do_clear();
        load_grid(WRAP_H);
        start_run(8'd1, 1'b1, 1'b0);
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== WRAP_V || to || busy !== 1'b0 || gen_count !== 8'd1)
            $display("FAIL wrap_torus: got %h busy=%b gc=%0d timeout=%b expected %h 0 1",
                     bits, busy, gen_count, to, WRAP_V);
        else pass_cnt++;
        do_clear();
        load_grid(WRAP_H);
        start_run(8'd1, 1'b0, 1'b0);
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== 36'd0 || to || extinct !== 1'b1)
            $display("FAIL wrap_dead_edge: got %h extinct=%b timeout=%b expected 0 1", bits, extinct, to);
        else pass_cnt++;
    endtask

    task automatic test_still_life();
        logic [35:0] bits;
        int le, he;
        bit to;
        do_clear();
        load_grid(BLOCK);
        start_run(8'd0, 1'b0, 1'b1);
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== BLOCK || to)
            $display("FAIL still_bits: got %h timeout=%b expected %h", bits, to, BLOCK);
        else pass_cnt++;
        total_cnt++;
        if (stable !== 1'b1 || gen_count !== 8'd1 || busy !== 1'b0 || extinct !== 1'b0)
            $display("FAIL still_status: stable=%b gc=%0d busy=%b extinct=%b expected 1 1 0 0",
                     stable, gen_count, busy, extinct);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [35:0] bits;
        int le, he;
        bit to;
        do_clear();
        load_grid(BLINK_H);
        start_run(8'd1, 1'b0, 1'b0);
        drain(1'b1, bits, le, he, to);
        total_cnt++;
        if (bits !== BLINK_V || to)
            $display("FAIL bp_bits: got %h timeout=%b expected %h", bits, to, BLINK_V);
        else pass_cnt++;
        total_cnt++;
        if (le != 0 || he != 0)
            $display("FAIL bp_last_hold: last_errs=%0d hold_errs=%0d expected 0 0", le, he);
        else pass_cnt++;
    endtask

    task automatic test_abort_reset();
        logic [35:0] bits;
        int le, he;
        bit to;
        do_clear();
        load_grid(BLINK_H);
        out_ready = 1'b1;
        start_run(8'd0, 1'b0, 1'b0);
        tick();
        repeat (10) tick();
        total_cnt++;
        if (out_valid !== 1'b1)
            $display("FAIL abort_in_drain: out_valid=%b expected 1", out_valid);
        else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || gen_count !== 8'd1)
            $display("FAIL abort_ready: v=%b busy=%b in_ready=%b gc=%0d expected 0 0 0 1",
                     out_valid, busy, in_ready, gen_count);
        else pass_cnt++;
        start_run(8'd1, 1'b0, 1'b0);
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== BLINK_H || to)
            $display("FAIL abort_grid_kept: got %h timeout=%b expected %h", bits, to, BLINK_H);
        else pass_cnt++;
        start_run(8'd0, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, out_bit, out_last, busy, in_ready, stable, extinct, gen_count} !==
            {7'b0000100, 8'h00})
            $display("FAIL reset_mid_drain: got v%b b%b l%b busy%b rdy%b st%b ex%b gc%0d expected rdy=1 rest 0",
                     out_valid, out_bit, out_last, busy, in_ready, stable, extinct, gen_count);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        logic [35:0] bits;
        int le, he;
        bit to;
        gens_req = 8'd1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL start_in_load: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        else pass_cnt++;
        load_grid(BLINK_H);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL in_valid_in_ready: in_ready=%b busy=%b expected 0 0", in_ready, busy);
        else pass_cnt++;
        out_ready = 1'b0;
        start_run(8'd1, 1'b0, 1'b0);
        tick();
        clear = 1'b1;
        repeat (2) tick();
        clear = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL clear_in_drain: out_valid=%b busy=%b expected 1 1", out_valid, busy);
        else pass_cnt++;
        drain(1'b0, bits, le, he, to);
        total_cnt++;
        if (bits !== BLINK_V || to || gen_count !== 8'd1)
            $display("FAIL illegal_grid: got %h gc=%0d timeout=%b expected %h 1", bits, gen_count, to, BLINK_V);
        else pass_cnt++;
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL clear_beats_start: in_ready=%b busy=%b expected 1 0", in_ready, busy);
        else pass_cnt++;
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_bit         = 1'b0;
        start          = 1'b0;
        gens_req       = 8'd0;
        wrap_en        = 1'b0;
        stop_on_stable = 1'b0;
        abort          = 1'b0;
        clear          = 1'b0;
        out_ready      = 1'b1;
        #2;
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_blinker();
        test_wrap();
        test_still_life();
        test_backpressure();
        test_abort_reset();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
